// File: rtl/led_pattern_gen.sv
// led_pattern_gen: drives the board LED from the 1 Hz tick with four display modes.
//   Modes: 0 OFF, 1 BLINK, 2 HEARTBEAT (rotating PATTERN), 3 BREATHE (PWM duty ramp).
//   A requested mode is adopted only on a tick, so the pattern never glitches mid-period.
//   Optional macro LED_GAMMA_EN: squares the duty (registered) before the PWM compare.
// Ports:
//   clk          in   fabric clock
//   rst_n        in   synchronous active-low reset
//   tick         in   single-cycle 1 Hz enable pulse
//   mode         in   [1:0] requested mode
//   led          out  registered LED drive
//   mode_active  out  [1:0] mode currently applied (registered)
module led_pattern_gen #(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned STEP     = 4,
  parameter logic [7:0]  PATTERN  = 8'b1010_0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [1:0] mode,
  output logic       led,
  output logic [1:0] mode_active
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_BLINK   = 2'd1,
    MODE_HEART   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  localparam int unsigned SW = PWM_BITS + 1;
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [SW-1:0] STEP_W = SW'(STEP);
  localparam logic [SW-1:0] MAX_W  = {1'b0, DUTY_MAX};

  mode_t               mode_q, mode_d;
  logic                blink_q, blink_d;
  logic [7:0]          pat_q, pat_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                dir_q, dir_d;
  logic                led_q, led_d;
  logic [PWM_BITS-1:0] duty_eff;
  logic                reinit;
  logic [SW-1:0]       sum, diff;

  // Duty value presented to the PWM compare.
`ifdef LED_GAMMA_EN
  localparam int unsigned PW = 2 * PWM_BITS;
  logic [PW-1:0]       sq;
  logic [PWM_BITS-1:0] eff_q, eff_d;

  // Gamma curve with forced endpoints so full scale stays full scale.
  always_comb begin
    sq    = PW'(duty_q) * PW'(duty_q);
    eff_d = PWM_BITS'(sq >> PWM_BITS);
    if (duty_q == DUTY_MAX) eff_d = DUTY_MAX;
    if (duty_q == '0)       eff_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) eff_q <= '0;
    else        eff_q <= eff_d;
  end

  assign duty_eff = eff_q;
`else
  assign duty_eff = duty_q;
`endif

  // Next-state and next-led logic.
  always_comb begin
    mode_d  = mode_q;
    blink_d = blink_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q + PWM_BITS'(1);
    duty_d  = duty_q;
    dir_d   = dir_q;
    led_d   = 1'b0;
    reinit  = tick && (mode != mode_q);
    sum     = {1'b0, duty_q} + STEP_W;
    diff    = {1'b0, duty_q} - STEP_W;

    if (tick) mode_d = mode_t'(mode);

    if (reinit) begin
      blink_d = 1'b0;
      pat_d   = PATTERN;
      duty_d  = '0;
      dir_d   = 1'b0;
    end else if (tick) begin
      case (mode_q)
        MODE_BLINK: blink_d = ~blink_q;
        MODE_HEART: pat_d   = {pat_q[0], pat_q[7:1]};
        default: ;
      endcase
    end

    // Saturating ramp at the last cycle of each PWM period; borrow bit catches underflow.
    if (cnt_q == DUTY_MAX && mode_q == MODE_BREATHE && !reinit) begin
      if (!dir_q) begin
        if (sum >= MAX_W) begin
          duty_d = DUTY_MAX;
          dir_d  = 1'b1;
        end else begin
          duty_d = sum[PWM_BITS-1:0];
        end
      end else begin
        if (diff[PWM_BITS] || diff == '0) begin
          duty_d = '0;
          dir_d  = 1'b0;
        end else begin
          duty_d = diff[PWM_BITS-1:0];
        end
      end
    end

    case (mode_q)
      MODE_OFF:     led_d = 1'b0;
      MODE_BLINK:   led_d = blink_q;
      MODE_HEART:   led_d = pat_q[0];
      MODE_BREATHE: led_d = (cnt_q < duty_eff);
      default:      led_d = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q  <= MODE_OFF;
      blink_q <= 1'b0;
      pat_q   <= PATTERN;
      cnt_q   <= '0;
      duty_q  <= '0;
      dir_q   <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      blink_q <= blink_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      led_q   <= led_d;
    end
  end

  assign led         = led_q;
  assign mode_active = mode_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Testbench for led_pattern_gen (PWM_BITS=4, STEP=5): directed table, BREATHE sweep,
// mid-ramp switch/reset sequence, then randomized traffic against a behavioural model.
module tb_led_pattern_gen;

  localparam int unsigned PB   = 4;
  localparam int unsigned STP  = 5;
  localparam int          MAXV = (1 << PB) - 1;
  localparam logic [7:0]  PAT  = 8'b1010_0000;
`ifdef LED_GAMMA_EN
  localparam bit GAMMA = 1'b1;
`else
  localparam bit GAMMA = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       led;
  logic [1:0] mode_active;

  int checks = 0;
  int failures = 0;

  led_pattern_gen #(.PWM_BITS(PB), .STEP(STP), .PATTERN(PAT)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .mode(mode),
    .led(led), .mode_active(mode_active)
  );

  always #5 clk = ~clk;

  // Behavioural model: pattern tracked as a rotation index, duty as a plain integer.
  int m_mode, m_blink, m_pidx, m_cnt, m_duty, m_dir, m_led, m_eff;
  bit m_valid = 1'b0;

  function automatic int gamma_of(input int d);
    if (d == MAXV) return MAXV;
    return (d * d) >> PB;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int eff, n_led, n_duty, n_dir, n_blink, n_pidx;
    bit reinit;
    logic [7:0] pv;
    if (!rst_n) begin
      m_mode = 0; m_blink = 0; m_pidx = 0; m_cnt = 0;
      m_duty = 0; m_dir = 0; m_led = 0; m_eff = 0;
      m_valid = 1'b1;
      return;
    end
    pv  = PAT;
    eff = GAMMA ? m_eff : m_duty;
    case (m_mode)
      1:       n_led = m_blink;
      2:       n_led = int'(pv[m_pidx]);
      3:       n_led = (m_cnt < eff) ? 1 : 0;
      default: n_led = 0;
    endcase
    reinit  = tick && (int'(mode) != m_mode);
    n_duty  = m_duty;
    n_dir   = m_dir;
    n_blink = m_blink;
    n_pidx  = m_pidx;
    if (reinit) begin
      n_duty = 0; n_dir = 0; n_blink = 0; n_pidx = 0;
    end else if (tick) begin
      if (m_mode == 1) n_blink = 1 - m_blink;
      if (m_mode == 2) n_pidx = (m_pidx + 1) % 8;
    end
    if (!reinit && m_cnt == MAXV && m_mode == 3) begin
      if (m_dir == 0) begin
        n_duty = (m_duty + STP > MAXV) ? MAXV : m_duty + STP;
        if (n_duty == MAXV) n_dir = 1;
      end else begin
        n_duty = (m_duty - STP < 0) ? 0 : m_duty - STP;
        if (n_duty == 0) n_dir = 0;
      end
    end
    m_eff   = gamma_of(m_duty);
    m_led   = n_led;
    m_duty  = n_duty;
    m_dir   = n_dir;
    m_blink = n_blink;
    m_pidx  = n_pidx;
    m_cnt   = (m_cnt + 1) % (MAXV + 1);
    if (tick) m_mode = int'(mode);
  endtask

  // One clock: model advances with the DUT, outputs compared #1 after the edge.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    if (m_valid) begin
      chk("model_led", {7'd0, led}, 8'(m_led));
      chk("model_mode", {6'd0, mode_active}, 8'(m_mode));
    end
  endtask

  task automatic apply(input logic r, input logic t, input logic [1:0] md, input int gap,
                       input logic el, input logic [1:0] em, input string name);
    rst_n = r; tick = t; mode = md;
    step();
    rst_n = 1'b1; tick = 1'b0;
    repeat (gap) step();
    chk({name, "_led"}, {7'd0, led}, {7'd0, el});
    chk({name, "_mode"}, {6'd0, mode_active}, {6'd0, em});
  endtask

  typedef struct {
    logic       r;
    logic       t;
    logic [1:0] md;
    int         gap;
    logic       el;
    logic [1:0] em;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int   exp_cnt[8];

  initial begin
    // Reset with tick pulsing, release, then BLINK and HEARTBEAT sequences.
    vecs.push_back('{1'b0, 1'b1, 2'd1, 0, 1'b0, 2'd0, "rst0"});
    vecs.push_back('{1'b0, 1'b1, 2'd1, 0, 1'b0, 2'd0, "rst1"});
    vecs.push_back('{1'b0, 1'b1, 2'd1, 0, 1'b0, 2'd0, "rst2"});
    vecs.push_back('{1'b1, 1'b0, 2'd1, 4, 1'b0, 2'd0, "post_rst"});
    vecs.push_back('{1'b1, 1'b1, 2'd1, 1, 1'b0, 2'd1, "blink_t1"});
    vecs.push_back('{1'b1, 1'b0, 2'd1, 17, 1'b0, 2'd1, "blink_i1"});
    vecs.push_back('{1'b1, 1'b1, 2'd1, 1, 1'b1, 2'd1, "blink_t2"});
    vecs.push_back('{1'b1, 1'b0, 2'd1, 17, 1'b1, 2'd1, "blink_i2"});
    vecs.push_back('{1'b1, 1'b1, 2'd1, 1, 1'b0, 2'd1, "blink_t3"});
    vecs.push_back('{1'b1, 1'b0, 2'd1, 17, 1'b0, 2'd1, "blink_i3"});
    vecs.push_back('{1'b1, 1'b1, 2'd1, 1, 1'b1, 2'd1, "blink_t4"});
    vecs.push_back('{1'b1, 1'b1, 2'd2, 1, 1'b0, 2'd2, "hb_t1"});
    vecs.push_back('{1'b1, 1'b1, 2'd2, 2, 1'b0, 2'd2, "hb_t2"});
    vecs.push_back('{1'b1, 1'b1, 2'd2, 2, 1'b0, 2'd2, "hb_t3"});
    vecs.push_back('{1'b1, 1'b1, 2'd2, 2, 1'b0, 2'd2, "hb_t4"});
    vecs.push_back('{1'b1, 1'b1, 2'd2, 2, 1'b0, 2'd2, "hb_t5"});
    vecs.push_back('{1'b1, 1'b1, 2'd2, 2, 1'b1, 2'd2, "hb_t6"});
    vecs.push_back('{1'b1, 1'b1, 2'd2, 2, 1'b0, 2'd2, "hb_t7"});
    vecs.push_back('{1'b1, 1'b1, 2'd2, 2, 1'b1, 2'd2, "hb_t8"});
    vecs.push_back('{1'b1, 1'b1, 2'd2, 2, 1'b0, 2'd2, "hb_t9"});
    vecs.push_back('{1'b1, 1'b1, 2'd2, 2, 1'b0, 2'd2, "hb_t10"});

    foreach (vecs[i])
      apply(vecs[i].r, vecs[i].t, vecs[i].md, vecs[i].gap, vecs[i].el, vecs[i].em, vecs[i].name);

    // BREATHE sweep: tick on the last cycle of a period so the first full period has duty 0.
    begin
      int duties[9];
      duties = '{0, 0, 5, 10, 15, 10, 5, 0, 5};
      for (int k = 0; k < 8; k++) begin
        if (GAMMA)
          exp_cnt[k] = ((gamma_of(duties[k]) > 0) ? 1 : 0) +
                       ((gamma_of(duties[k + 1]) > 1) ? gamma_of(duties[k + 1]) - 1 : 0);
        else
          exp_cnt[k] = duties[k + 1];
      end
    end
    for (int i = 0; i < 20 && m_cnt != MAXV; i++) step();
    chk("breathe_align", 8'(m_cnt), 8'(MAXV));
    mode = 2'd3; tick = 1'b1;
    step();
    tick = 1'b0;
    for (int k = 0; k < 8; k++) begin
      int highs;
      highs = 0;
      for (int c = 0; c <= MAXV; c++) begin
        step();
        highs += int'(led);
      end
      chk($sformatf("breathe_p%0d", k), 8'(highs), 8'(exp_cnt[k]));
    end

    // Switch to BLINK mid-ramp (duty=10), then reset coinciding with a tick.
    apply(1'b1, 1'b1, 2'd1, 1, 1'b0, 2'd1, "midramp_sw");
    apply(1'b0, 1'b1, 2'd2, 0, 1'b0, 2'd0, "rst_tick");
    apply(1'b1, 1'b0, 2'd2, 3, 1'b0, 2'd0, "rst_tick_after");

    // Randomized traffic compared every cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      tick  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 79) == 0) mode = 2'($urandom_range(0, 3));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
